// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: load-tracker state
// encoding, exception codes and the stage payload layout with its reset value.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } ld_state_e;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wbdata;
    logic        exception;
    logic [4:0]  exccode;
  } mem_payload_t;

  localparam mem_payload_t PAYLOAD_RST = '0;
  localparam logic [31:0]  RDATA_RST   = '0;

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM->WB handshake, payload and data-SRAM response bundle for mem_stage.
// Forwarding signals exist only when MEM_FWD_EN is defined.
interface mem_stage_if;
  logic        ex_valid_in;
  logic        mem_allowin_out;
  logic        mem_valid_out;
  logic        wb_allowin_in;

  logic [31:0] ex_PC_in;
  logic [4:0]  ex_wnum_in;
  logic [31:0] ex_wbdata_in;
  logic        ex_load_in;
  logic        ex_exception_in;
  logic [4:0]  ex_ExcCode_in;

  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic        wb_ClrStpJmp_in;

  logic [31:0] mem_PC_out;
  logic [4:0]  mem_wnum_out;
  logic [31:0] mem_wbdata_out;
  logic [31:0] mem_dm_data_out;
  logic [1:0]  mem_adrl_out;
  logic        mem_exception_out;
  logic [4:0]  mem_ExcCode_out;
`ifdef MEM_FWD_EN
  logic        mem_fwd_we_out;
  logic [4:0]  mem_fwd_wnum_out;
  logic [31:0] mem_fwd_data_out;
`endif

  modport slave (
    input  ex_valid_in, wb_allowin_in, ex_PC_in, ex_wnum_in, ex_wbdata_in,
           ex_load_in, ex_exception_in, ex_ExcCode_in, data_sram_rdata,
           data_sram_data_ok, wb_ClrStpJmp_in,
    output mem_allowin_out, mem_valid_out, mem_PC_out, mem_wnum_out,
           mem_wbdata_out, mem_dm_data_out, mem_adrl_out, mem_exception_out,
           mem_ExcCode_out
`ifdef MEM_FWD_EN
    , output mem_fwd_we_out, mem_fwd_wnum_out, mem_fwd_data_out
`endif
  );

  modport master (
    output ex_valid_in, wb_allowin_in, ex_PC_in, ex_wnum_in, ex_wbdata_in,
           ex_load_in, ex_exception_in, ex_ExcCode_in, data_sram_rdata,
           data_sram_data_ok, wb_ClrStpJmp_in,
    input  mem_allowin_out, mem_valid_out, mem_PC_out, mem_wnum_out,
           mem_wbdata_out, mem_dm_data_out, mem_adrl_out, mem_exception_out,
           mem_ExcCode_out
`ifdef MEM_FWD_EN
    , input mem_fwd_we_out, mem_fwd_wnum_out, mem_fwd_data_out
`endif
  );
endinterface

// File: rtl/mem_load_tracker.sv
// Tracks the outstanding data-SRAM load for the MEM stage and buffers its
// read data; responses belonging to flushed loads are counted and discarded.
module mem_load_tracker
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load_enter,
  input  logic        i_flush,
  input  logic        i_data_ok,
  input  logic [31:0] i_rdata,
  output logic        o_load_pending,
  output logic [31:0] o_rdata_buf
);

  ld_state_e   r_state;
  ld_state_e   w_state_nxt;
  logic [1:0]  r_drop_cnt;
  logic [1:0]  w_drop_cnt_nxt;
  logic [1:0]  w_drop_left;
  logic        r_live;
  logic        w_live_nxt;
  logic        w_live_left;
  logic        w_capture;
  logic [31:0] r_rdata_buf;

  // NOTE: reset is synchronous, so it is sampled inside the clocked branch and
  // every state register uses non-blocking assignment to avoid ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_drop_cnt <= '0;
      r_live     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
      r_live     <= w_live_nxt;
    end
  end

  // In DROP, r_drop_cnt counts stale responses still due and r_live marks a
  // newer load queued behind them; a flush of that load makes it stale too.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_state_nxt    = r_state;
    w_drop_cnt_nxt = r_drop_cnt;
    w_live_nxt     = r_live;
    w_drop_left    = r_drop_cnt + {1'b0, i_flush & r_live} - {1'b0, i_data_ok};
    w_live_left    = (r_live & ~i_flush) | i_load_enter;
    unique case (r_state)
      ST_IDLE: if (i_load_enter) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i_data_ok) begin
          w_state_nxt = ST_IDLE;
        end else if (i_flush) begin
          w_state_nxt    = ST_DROP;
          w_drop_cnt_nxt = 2'd1;
          w_live_nxt     = 1'b0;
        end
      end
      ST_DROP: begin
        if (w_drop_left == 2'd0) begin
          w_state_nxt    = w_live_left ? ST_WAIT : ST_IDLE;
          w_drop_cnt_nxt = 2'd0;
          w_live_nxt     = 1'b0;
        end else begin
          w_drop_cnt_nxt = w_drop_left;
          w_live_nxt     = w_live_left;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_load_pending = (r_state == ST_WAIT) | ((r_state == ST_DROP) & r_live);
    w_capture      = (r_state == ST_WAIT) & i_data_ok & ~i_flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         r_rdata_buf <= RDATA_RST;
    else if (w_capture) r_rdata_buf <= i_rdata;
  end

  assign o_rdata_buf = r_rdata_buf;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM stage register with valid/allowin handshake and
// load stalling. Optional MEM_FWD_EN adds a register-forwarding port to EX.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  mem_stage_if.slave  bus
);

  logic         r_valid;
  mem_payload_t r_pl;
  mem_payload_t w_pl_in;
  logic         w_flush;
  logic         w_ready;
  logic         w_allowin;
  logic         w_accept;
  logic         w_load_enter;
  logic         w_load_pending;
  logic [31:0]  w_rdata_buf;

  assign w_flush      = bus.wb_ClrStpJmp_in;
  assign w_ready      = ~w_load_pending;
  assign w_allowin    = ~r_valid | (w_ready & bus.wb_allowin_in);
  assign w_accept     = bus.ex_valid_in & w_allowin & ~w_flush;
  assign w_load_enter = w_accept & bus.ex_load_in & ~bus.ex_exception_in;

  assign w_pl_in = '{
    pc:        bus.ex_PC_in,
    wnum:      bus.ex_wnum_in,
    wbdata:    bus.ex_wbdata_in,
    exception: bus.ex_exception_in,
    exccode:   bus.ex_ExcCode_in
  };

  always_ff @(posedge clk) begin
    if (!rst_n || w_flush) begin
      r_valid <= 1'b0;
      r_pl    <= PAYLOAD_RST;
    end else if (w_allowin) begin
      r_valid <= bus.ex_valid_in;
      if (bus.ex_valid_in) r_pl <= w_pl_in;
    end
  end

  mem_load_tracker u_tracker (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load_enter   (w_load_enter),
    .i_flush        (w_flush),
    .i_data_ok      (bus.data_sram_data_ok),
    .i_rdata        (bus.data_sram_rdata),
    .o_load_pending (w_load_pending),
    .o_rdata_buf    (w_rdata_buf)
  );

  assign bus.mem_allowin_out   = w_allowin;
  assign bus.mem_valid_out     = r_valid & w_ready & ~w_flush;
  assign bus.mem_PC_out        = r_pl.pc;
  assign bus.mem_wnum_out      = r_pl.wnum;
  assign bus.mem_wbdata_out    = r_pl.wbdata;
  assign bus.mem_adrl_out      = r_pl.wbdata[1:0];
  assign bus.mem_dm_data_out   = w_rdata_buf;
  assign bus.mem_exception_out = r_pl.exception;
  assign bus.mem_ExcCode_out   = r_pl.exccode;

`ifdef MEM_FWD_EN
  // The load flag is only needed to suppress forwarding of not-yet-loaded data.
  logic r_load;

  always_ff @(posedge clk) begin
    if (!rst_n || w_flush)                r_load <= 1'b0;
    else if (w_allowin && bus.ex_valid_in) r_load <= bus.ex_load_in;
  end

  assign bus.mem_fwd_we_out   = r_valid & ~r_load & ~r_pl.exception & (r_pl.wnum != 5'd0);
  assign bus.mem_fwd_wnum_out = r_pl.wnum;
  assign bus.mem_fwd_data_out = r_pl.wbdata;
`endif

endmodule
